// File: rtl/and4_response_checker.sv
// Response checker for a 4-input AND gate stage.
// The stage computes oute = ina & inb, outf = inc & ind, outg = oute & outf.
// The checker samples the stage inputs and outputs every clock. Once the input
// vector has been stable for SETTLE_CYCLES cycles, it compares the sampled
// outputs against the expected values. It counts checks and mismatches, and it
// captures the first failing vector for board-level debug.
//
// Ports:
//   clk             in   system clock, rising edge
//   rst             in   synchronous reset, active-high
//   en              in   run enable; low returns to IDLE with counters held
//   ina..ind        in   stimulus applied to the AND stage (async to clk)
//   oute,outf,outg  in   AND stage outputs under check
//   check_valid     out  1-cycle pulse: a compare was performed
//   check_pass      out  compare result, valid with check_valid
//   chk_cnt         out  checks performed (saturating)
//   err_cnt         out  mismatches seen (saturating)
//   fail_seen       out  sticky: at least one mismatch since reset
//   first_fail_vec  out  {ina,inb,inc,ind} of the first mismatch
//   first_fail_got  out  {oute,outf,outg} observed at the first mismatch
//   done            out  high while in DONE

module and4_response_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned NUM_CHECKS    = 16,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ina,
    input  logic             inb,
    input  logic             inc,
    input  logic             ind,
    input  logic             oute,
    input  logic             outf,
    input  logic             outg,
    output logic             check_valid,
    output logic             check_pass,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             fail_seen,
    output logic [3:0]       first_fail_vec,
    output logic [2:0]       first_fail_got,
    output logic             done
);

    // The settle counter only ever holds 0..SETTLE_CYCLES-1.
    localparam int unsigned    SET_W      = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0] SET_RELOAD = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(NUM_CHECKS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_CHECK,
        S_HOLD,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [3:0]         r_in_q;
    logic [3:0]         r_in_qq;
    logic [2:0]         r_out_q;
    logic [SET_W-1:0]   r_cnt;

    logic               w_chg;
    logic [2:0]         w_exp;
    logic               w_match;
    logic [CNT_W-1:0]   w_chk_inc;

    // Sampled vector moved since last cycle: the stage is not settled yet.
    assign w_chg     = (r_in_q != r_in_qq);
    assign w_exp     = {r_in_q[3] & r_in_q[2], r_in_q[1] & r_in_q[0], &r_in_q};
    assign w_match   = (r_out_q == w_exp);
    assign w_chk_inc = (chk_cnt == CNT_MAX) ? chk_cnt : chk_cnt + CNT_W'(1);

    // Input/output sampling, active in every state including IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_q  <= 4'b0000;
            r_in_qq <= 4'b0000;
            r_out_q <= 3'b000;
        end else begin
            r_in_q  <= {ina, inb, inc, ind};
            r_in_qq <= r_in_q;
            r_out_q <= {oute, outf, outg};
        end
    end

    // Check sequencer with registered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            check_valid    <= 1'b0;
            check_pass     <= 1'b0;
            chk_cnt        <= '0;
            err_cnt        <= '0;
            fail_seen      <= 1'b0;
            first_fail_vec <= 4'b0000;
            first_fail_got <= 3'b000;
            done           <= 1'b0;
        end else begin
            check_valid <= 1'b0;
            check_pass  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (en) begin
                        r_state <= S_WAIT;
                        r_cnt   <= SET_RELOAD;
                    end
                end

                // A change on the last settle cycle reloads instead of checking.
                S_WAIT: begin
                    if (!en) begin
                        r_state <= S_IDLE;
                    end else if (w_chg) begin
                        r_cnt <= SET_RELOAD;
                    end else if (r_cnt == '0) begin
                        r_state <= S_CHECK;
                    end else begin
                        r_cnt <= r_cnt - SET_W'(1);
                    end
                end

                // The compare always completes, even if en dropped this cycle.
                S_CHECK: begin
                    check_valid <= 1'b1;
                    check_pass  <= w_match;
                    chk_cnt     <= w_chk_inc;
                    if (!w_match) begin
                        if (err_cnt != CNT_MAX) begin
                            err_cnt <= err_cnt + CNT_W'(1);
                        end
                        if (!fail_seen) begin
                            first_fail_vec <= r_in_q;
                            first_fail_got <= r_out_q;
                            fail_seen      <= 1'b1;
                        end
                    end
                    // Reaching the check budget takes priority over en.
                    if (w_chk_inc == CNT_TARGET) begin
                        r_state <= S_DONE;
                        done    <= 1'b1;
                    end else if (!en) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_HOLD;
                    end
                end

                // Only a fresh vector re-arms the settle timer.
                S_HOLD: begin
                    if (!en) begin
                        r_state <= S_IDLE;
                    end else if (w_chg) begin
                        r_state <= S_WAIT;
                        r_cnt   <= SET_RELOAD;
                    end
                end

                // Terminal until reset; en is ignored.
                S_DONE: begin
                    done <= 1'b1;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_and4_response_checker.sv
module tb_and4_response_checker;

    localparam int unsigned A_SETTLE = 1;
    localparam int unsigned A_NUM    = 16;
    localparam int unsigned A_W      = 8;
    localparam int unsigned B_SETTLE = 3;
    localparam int unsigned B_NUM    = 3;
    localparam int unsigned B_W      = 2;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic ina, inb, inc, ind;
    logic oute, outf, outg;
    int   fault_mode;   // 0 golden, 1 outg stuck-0, 2 all outputs inverted

    logic           a_valid, a_pass, a_fail, a_done;
    logic [A_W-1:0] a_chk, a_err;
    logic [3:0]     a_ffv;
    logic [2:0]     a_ffg;

    logic           b_valid, b_pass, b_fail, b_done;
    logic [B_W-1:0] b_chk, b_err;
    logic [3:0]     b_ffv;
    logic [2:0]     b_ffg;

    int n_checks = 0;
    int n_fails  = 0;

    bit q_a[$];
    bit q_b[$];

    always #5 clk = ~clk;

    // AND stage model with optional fault injection.
    assign oute = (fault_mode == 2) ? ~(ina & inb) : (ina & inb);
    assign outf = (fault_mode == 2) ? ~(inc & ind) : (inc & ind);
    assign outg = (fault_mode == 1) ? 1'b0 :
                  (fault_mode == 2) ? ~(ina & inb & inc & ind) : (ina & inb & inc & ind);

    and4_response_checker #(
        .SETTLE_CYCLES(A_SETTLE), .NUM_CHECKS(A_NUM), .CNT_W(A_W)
    ) dut_a (
        .clk(clk), .rst(rst), .en(en),
        .ina(ina), .inb(inb), .inc(inc), .ind(ind),
        .oute(oute), .outf(outf), .outg(outg),
        .check_valid(a_valid), .check_pass(a_pass),
        .chk_cnt(a_chk), .err_cnt(a_err), .fail_seen(a_fail),
        .first_fail_vec(a_ffv), .first_fail_got(a_ffg), .done(a_done)
    );

    and4_response_checker #(
        .SETTLE_CYCLES(B_SETTLE), .NUM_CHECKS(B_NUM), .CNT_W(B_W)
    ) dut_b (
        .clk(clk), .rst(rst), .en(en),
        .ina(ina), .inb(inb), .inc(inc), .ind(ind),
        .oute(oute), .outf(outf), .outg(outg),
        .check_valid(b_valid), .check_pass(b_pass),
        .chk_cnt(b_chk), .err_cnt(b_err), .fail_seen(b_fail),
        .first_fail_vec(b_ffv), .first_fail_got(b_ffg), .done(b_done)
    );

    function automatic logic [2:0] golden(input logic [3:0] v);
        return {v[3] & v[2], v[1] & v[0], v[3] & v[2] & v[1] & v[0]};
    endfunction

    function automatic logic [2:0] stage(input logic [3:0] v, input int f);
        logic [2:0] g;
        g = golden(v);
        if (f == 1) return {g[2:1], 1'b0};
        if (f == 2) return ~g;
        return g;
    endfunction

    task automatic set_vec(input logic [3:0] v);
        {ina, inb, inc, ind} = v;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        fault_mode = 0;
        set_vec(4'b0000);
        q_a.delete();
        q_b.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b0;
        fault_mode = 0;
        set_vec(4'b0000);
        repeat (3) @(negedge clk);
        n_checks++;
        if ({a_valid, a_pass, a_fail, a_done, a_chk, a_err, a_ffv, a_ffg} !== '0) begin
            n_fails++;
            $display("FAIL reset_a: got %b expected all zero",
                     {a_valid, a_pass, a_fail, a_done, a_chk, a_err, a_ffv, a_ffg});
        end
        n_checks++;
        if ({b_valid, b_pass, b_fail, b_done, b_chk, b_err, b_ffv, b_ffg} !== '0) begin
            n_fails++;
            $display("FAIL reset_b: got %b expected all zero",
                     {b_valid, b_pass, b_fail, b_done, b_chk, b_err, b_ffv, b_ffg});
        end
        rst = 1'b0;
    endtask

    // One input toggles every 20 ns; 16 passing checks, then DONE.
    task automatic test_golden_run();
        logic [3:0] v;
        bit exp_p;
        do_reset();
        for (int i = 0; i < int'(A_NUM); i++) q_a.push_back(1'b1);
        en = 1'b1;
        v  = 4'b0000;
        for (int k = 0; k < 48; k++) begin
            v = v ^ (4'b1000 >> (k % 4));
            set_vec(v);
            repeat (2) begin
                @(negedge clk);
                if (a_valid) begin
                    n_checks++;
                    if (q_a.size() == 0) begin
                        n_fails++;
                        $display("FAIL golden_run: unexpected check_valid, got pass=%0b expected no pulse", a_pass);
                    end else begin
                        exp_p = q_a.pop_front();
                        if (a_pass !== exp_p) begin
                            n_fails++;
                            $display("FAIL golden_run_pass: got %0b expected %0b", a_pass, exp_p);
                        end
                    end
                end
            end
        end
        n_checks++;
        if (q_a.size() != 0) begin
            n_fails++;
            $display("FAIL golden_run_pulses: %0d checks missing, expected 0", q_a.size());
        end
        n_checks++;
        if (a_chk !== 8'd16 || a_err !== 8'd0) begin
            n_fails++;
            $display("FAIL golden_run_cnt: got chk=%0d err=%0d expected chk=16 err=0", a_chk, a_err);
        end
        n_checks++;
        if (a_done !== 1'b1 || a_fail !== 1'b0) begin
            n_fails++;
            $display("FAIL golden_run_flags: got done=%0b fail_seen=%0b expected 1/0", a_done, a_fail);
        end
    endtask

    // outg stuck at 0: only 1111 exposes it.
    task automatic test_first_fail();
        logic [3:0] vecs [3];
        bit exp_p;
        vecs = '{4'b0000, 4'b1100, 4'b1111};
        do_reset();
        fault_mode = 1;
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_vec(vecs[i]);
            q_a.push_back(stage(vecs[i], fault_mode) == golden(vecs[i]));
            repeat (6) begin
                @(negedge clk);
                if (a_valid) begin
                    n_checks++;
                    if (q_a.size() == 0) begin
                        n_fails++;
                        $display("FAIL first_fail: unexpected check_valid, got pass=%0b expected no pulse", a_pass);
                    end else begin
                        exp_p = q_a.pop_front();
                        if (a_pass !== exp_p) begin
                            n_fails++;
                            $display("FAIL first_fail_pass: vec=%b got %0b expected %0b", vecs[i], a_pass, exp_p);
                        end
                    end
                end
            end
        end
        n_checks++;
        if (q_a.size() != 0) begin
            n_fails++;
            $display("FAIL first_fail_pulses: %0d checks missing, expected 0", q_a.size());
        end
        n_checks++;
        if (a_err !== 8'd1 || a_fail !== 1'b1 || a_chk !== 8'd3) begin
            n_fails++;
            $display("FAIL first_fail_cnt: got err=%0d fail=%0b chk=%0d expected 1/1/3", a_err, a_fail, a_chk);
        end
        n_checks++;
        if (a_ffv !== 4'b1111 || a_ffg !== 3'b110) begin
            n_fails++;
            $display("FAIL first_fail_capture: got vec=%b out=%b expected 1111/110", a_ffv, a_ffg);
        end
    endtask

    // Vector moving every clock never settles; then one check at the exact latency.
    task automatic test_settle();
        bit exp_p;
        int pulses;
        int pulse_at;
        pulses   = 0;
        pulse_at = 0;
        do_reset();
        en = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            set_vec(4'(i) ^ 4'b0101);
            @(negedge clk);
            if (b_valid) begin
                n_checks++;
                n_fails++;
                $display("FAIL settle_toggle: check_valid=1 at toggle %0d expected 0", i);
            end
        end
        set_vec(4'b1010);
        q_b.push_back(1'b1);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (b_valid) begin
                pulses++;
                if (pulse_at == 0) pulse_at = c;
                n_checks++;
                if (q_b.size() == 0) begin
                    n_fails++;
                    $display("FAIL settle: unexpected check_valid at cycle %0d, expected no pulse", c);
                end else begin
                    exp_p = q_b.pop_front();
                    if (b_pass !== exp_p) begin
                        n_fails++;
                        $display("FAIL settle_pass: got %0b expected %0b", b_pass, exp_p);
                    end
                end
            end
        end
        n_checks++;
        if (pulses != 1) begin
            n_fails++;
            $display("FAIL settle_count: got %0d pulses expected 1", pulses);
        end
        n_checks++;
        if (pulse_at != int'(B_SETTLE) + 3) begin
            n_fails++;
            $display("FAIL settle_latency: pulse at negedge %0d expected %0d", pulse_at, int'(B_SETTLE) + 3);
        end
    endtask

    // 2-bit counters, 3 checks, every compare fails: counters stop at 3.
    task automatic test_saturation();
        logic [3:0] vecs [5];
        bit exp_p;
        vecs = '{4'b0000, 4'b0101, 4'b1111, 4'b0011, 4'b1100};
        do_reset();
        fault_mode = 2;
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_vec(vecs[i]);
            if (i < int'(B_NUM)) q_b.push_back(stage(vecs[i], fault_mode) == golden(vecs[i]));
            repeat (9) begin
                @(negedge clk);
                if (b_valid) begin
                    n_checks++;
                    if (q_b.size() == 0) begin
                        n_fails++;
                        $display("FAIL saturation: unexpected check_valid at vec=%b, expected no pulse", vecs[i]);
                    end else begin
                        exp_p = q_b.pop_front();
                        if (b_pass !== exp_p) begin
                            n_fails++;
                            $display("FAIL saturation_pass: got %0b expected %0b", b_pass, exp_p);
                        end
                    end
                end
            end
        end
        n_checks++;
        if (q_b.size() != 0) begin
            n_fails++;
            $display("FAIL saturation_pulses: %0d checks missing, expected 0", q_b.size());
        end
        n_checks++;
        if (b_chk !== 2'd3 || b_err !== 2'd3 || b_done !== 1'b1) begin
            n_fails++;
            $display("FAIL saturation_cnt: got chk=%0d err=%0d done=%0b expected 3/3/1", b_chk, b_err, b_done);
        end
        n_checks++;
        if (b_ffv !== 4'b0000 || b_ffg !== 3'b111) begin
            n_fails++;
            $display("FAIL saturation_capture: got vec=%b out=%b expected 0000/111", b_ffv, b_ffg);
        end
    endtask

    // Reset pulse while a check is pending in WAIT.
    task automatic test_reset_mid();
        logic [3:0] vecs [2];
        bit exp_p;
        vecs = '{4'b0000, 4'b0110};
        do_reset();
        fault_mode = 2;
        en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_vec(vecs[i]);
            q_a.push_back(stage(vecs[i], fault_mode) == golden(vecs[i]));
            repeat (6) begin
                @(negedge clk);
                if (a_valid) begin
                    n_checks++;
                    if (q_a.size() == 0) begin
                        n_fails++;
                        $display("FAIL reset_mid: unexpected check_valid, expected no pulse");
                    end else begin
                        exp_p = q_a.pop_front();
                        if (a_pass !== exp_p) begin
                            n_fails++;
                            $display("FAIL reset_mid_pass: got %0b expected %0b", a_pass, exp_p);
                        end
                    end
                end
            end
        end
        n_checks++;
        if (a_err !== 8'd2) begin
            n_fails++;
            $display("FAIL reset_mid_pre: got err=%0d expected 2", a_err);
        end
        set_vec(4'b1001);
        repeat (2) begin
            @(negedge clk);
            if (a_valid) begin
                n_checks++;
                n_fails++;
                $display("FAIL reset_mid_wait: check_valid=1 expected 0");
            end
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({a_valid, a_pass, a_fail, a_done, a_chk, a_err, a_ffv, a_ffg} !== '0) begin
            n_fails++;
            $display("FAIL reset_mid_clear: got %b expected all zero",
                     {a_valid, a_pass, a_fail, a_done, a_chk, a_err, a_ffv, a_ffg});
        end
        q_a.push_back(stage(4'b1001, fault_mode) == golden(4'b1001));
        repeat (8) begin
            @(negedge clk);
            if (a_valid) begin
                n_checks++;
                if (q_a.size() == 0) begin
                    n_fails++;
                    $display("FAIL reset_mid_resume: unexpected check_valid, expected no pulse");
                end else begin
                    exp_p = q_a.pop_front();
                    if (a_pass !== exp_p) begin
                        n_fails++;
                        $display("FAIL reset_mid_resume_pass: got %0b expected %0b", a_pass, exp_p);
                    end
                end
            end
        end
        n_checks++;
        if (q_a.size() != 0 || a_chk !== 8'd1 || a_err !== 8'd1) begin
            n_fails++;
            $display("FAIL reset_mid_after: got missing=%0d chk=%0d err=%0d expected 0/1/1", q_a.size(), a_chk, a_err);
        end
        n_checks++;
        if (a_ffv !== 4'b1001 || a_ffg !== 3'b111) begin
            n_fails++;
            $display("FAIL reset_mid_capture: got vec=%b out=%b expected 1001/111", a_ffv, a_ffg);
        end
    endtask

    // en dropped in HOLD holds the counters; re-enable checks the next settled vector.
    task automatic test_en_drop();
        logic [3:0] vecs [5];
        bit exp_p;
        vecs = '{4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_vec(vecs[i]);
            q_a.push_back(1'b1);
            repeat (6) begin
                @(negedge clk);
                if (a_valid) begin
                    n_checks++;
                    if (q_a.size() == 0) begin
                        n_fails++;
                        $display("FAIL en_drop: unexpected check_valid, expected no pulse");
                    end else begin
                        exp_p = q_a.pop_front();
                        if (a_pass !== exp_p) begin
                            n_fails++;
                            $display("FAIL en_drop_pass: got %0b expected %0b", a_pass, exp_p);
                        end
                    end
                end
            end
        end
        en = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (c == 3) set_vec(4'b1110);
            @(negedge clk);
            if (a_valid) begin
                n_checks++;
                n_fails++;
                $display("FAIL en_drop_idle: check_valid=1 with en=0 expected 0");
            end
        end
        n_checks++;
        if (a_chk !== 8'd5) begin
            n_fails++;
            $display("FAIL en_drop_hold: got chk=%0d expected 5", a_chk);
        end
        en = 1'b1;
        q_a.push_back(1'b1);
        repeat (6) begin
            @(negedge clk);
            if (a_valid) begin
                n_checks++;
                if (q_a.size() == 0) begin
                    n_fails++;
                    $display("FAIL en_drop_resume: unexpected check_valid, expected no pulse");
                end else begin
                    exp_p = q_a.pop_front();
                    if (a_pass !== exp_p) begin
                        n_fails++;
                        $display("FAIL en_drop_resume_pass: got %0b expected %0b", a_pass, exp_p);
                    end
                end
            end
        end
        n_checks++;
        if (q_a.size() != 0 || a_chk !== 8'd6 || a_done !== 1'b0) begin
            n_fails++;
            $display("FAIL en_drop_after: got missing=%0d chk=%0d done=%0b expected 0/6/0", q_a.size(), a_chk, a_done);
        end
    endtask

    initial begin
        test_reset();
        test_golden_run();
        test_first_fail();
        test_settle();
        test_saturation();
        test_reset_mid();
        test_en_drop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
